// File: rtl/router_pkg.sv
// Shared types and constants for the router master/slave bus endpoints.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } ms_state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ms_slave_mem.sv
// Word storage for ms_slave_responder: synchronous write, asynchronous read,
// whole array cleared by reset.
module ms_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ms_slave_responder.sv
// Bus responder: latches single-beat requests, waits WAIT_STATES cycles, acks.
// Optional address-range error reporting is enabled with MS_SLAVE_ERR_EN.
module ms_slave_responder
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata
`ifdef MS_SLAVE_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int         ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);

    ms_state_t             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // In IDLE the request being accepted is still on the inputs; afterwards the latch holds it.
    assign cur_addr         = (state_q == IDLE) ? addr : addr_q;
    assign cur_we           = (state_q == IDLE) ? we : we_q;
    assign unused_addr_bits = ^cur_addr;

`ifdef MS_SLAVE_ERR_EN
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

    logic err_q, err_d;
    logic oob;

    assign oob    = |(cur_addr >> (ADDR_LSB + IDX_W));
    assign mem_we = (state_q == ACK) && we_q && !err_q;
    assign err    = err_q;
`else
    assign mem_we = (state_q == ACK) && we_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d   = (state_d == ACK);
        rdata_d = '0;
        if (ack_d && !cur_we) begin
            rdata_d = mem_rdata;
        end
`ifdef MS_SLAVE_ERR_EN
        err_d = ack_d && oob;
        if (err_d && !cur_we) begin
            rdata_d = ERR_WORD;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MS_SLAVE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifdef MS_SLAVE_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    ms_slave_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we),
        .idx_i  (cur_addr[ADDR_LSB +: IDX_W]),
        .wdata_i(wdata_q),
        .rdata_o(mem_rdata)
    );

    assign ack   = ack_q;
    assign rdata = rdata_q;

endmodule

// File: doc/ms_slave_responder.md
# ms_slave_responder

Responder (slave) end of the router's master/slave bus. It accepts single-beat read/write requests from a bus master, inserts a fixed number of wait states, and completes each transfer with a one-cycle `ack` pulse. Reads return data from an internal word-addressed memory. It sits behind `router_top` as a bus endpoint and replaces the constant `ack = 0` tie-off used in bring-up.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width in bits; a multiple of 8.
- `ADDR_WIDTH`, 32, byte-address width.
- `MEM_DEPTH`, 256, number of `DATA_WIDTH` words; a power of two.
- `WAIT_STATES`, 1, idle cycles between accept and `ack`; range 0..15.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: master request valid.
- `we` input 1: 1 = write, 0 = read; qualified by `req`.
- `addr` input `ADDR_WIDTH`: byte address; qualified by `req`.
- `wdata` input `DATA_WIDTH`: write data; qualified by `req && we`.
- `ack` output 1: transfer complete; one-cycle pulse.
- `rdata` output `DATA_WIDTH`: read data; valid only while `ack` is high for a read.
- `err` output 1: present only when `MS_SLAVE_ERR_EN` is defined.

## Operation
- FSM states are IDLE, WAIT, ACK.
- IDLE: if `req` is sampled high, latch `addr`/`we`/`wdata`. Go to WAIT if `WAIT_STATES > 0`, otherwise go to ACK.
- WAIT: a down-counter is loaded with `WAIT_STATES` on accept and decrements each cycle. Go to ACK when the count reaches 1. The counter width is 4 bits.
- ACK: `ack = 1` for exactly one cycle, then return to IDLE.
  - Writes commit to memory on this edge.
  - For reads, `rdata` is driven from memory during this cycle.
- Word index is `addr[ADDR_LSB +: $clog2(MEM_DEPTH)]`, with `ADDR_LSB = $clog2(DATA_WIDTH/8)`. Low byte-offset bits are ignored.
- The request is latched at accept. Changes on `addr`/`wdata`/`we` after accept have no effect.
- If `req` drops during WAIT (a protocol violation), the transfer still completes and `ack` still pulses.
- `rdata` is 0 whenever `ack` is low or the access is a write.
- Reset (asynchronous, at any time, including mid-WAIT):
  - State goes to IDLE, the counter to 0, and `ack`, `rdata`, `err` to 0.
  - The whole memory is cleared to 0. No pending write is committed.

## Timing
- Accept edge is T0, where `req` is high in IDLE.
- `ack` is high in cycle T0+1+`WAIT_STATES`. With `WAIT_STATES=0`, `ack` is high in the cycle after accept.
- A transfer ends on the edge where `req && ack`. The master drops `req` or presents a new request at that edge.
- Back-to-back: if `req` is high in the IDLE cycle after ACK, it is accepted. Throughput is one transfer per `WAIT_STATES+2` cycles.
- Read-after-write to the same address in consecutive transfers returns the new data.
- `ack` and `rdata` are registered outputs, with no combinational path from inputs.

## Configuration
- `MS_SLAVE_ERR_EN` defined:
  - The `err` port exists and is asserted together with `ack` when any `addr` bit above the index field is nonzero.
  - On an error, writes are discarded and reads return `ERR_DATA` (`32'hDEAD_BEEF`, truncated or zero-extended to `DATA_WIDTH`).
  - Timing is unchanged.
- `MS_SLAVE_ERR_EN` undefined:
  - There is no `err` port.
  - Upper address bits are ignored, so addresses alias and wrap modulo `MEM_DEPTH` words.

## Structure
- Shared package `router_pkg` holds:
  - the `ms_state_t` enum (IDLE, WAIT, ACK);
  - `ERR_DATA`;
  - a helper function for `ADDR_LSB`.
- Sub-module `ms_slave_mem` is the storage array. It has a synchronous write port and an asynchronous read port, with the reset-clear loop inside it.
- `ms_slave_responder` contains the FSM, the wait counter, the request latch, and the output registers.

## Test plan
- Reset values: hold `rst` for 3 cycles and check `ack=0`, `rdata=0`, `err=0`. A read of 0x0 then returns 0.
- `WAIT_STATES=1`:
  - Write `0x1234_5678` to 0x10: `ack` pulses exactly at T0+2, one cycle wide.
  - Read 0x10: `ack` at T0+2 with `rdata=0x1234_5678`.
  - Read 0x13: same data, since byte offset bits are ignored.
- `WAIT_STATES=0` and `WAIT_STATES=3`, back-to-back writes to 0x0/0x4 then reads:
  - Check `ack` spacing of 2 and 5 cycles respectively.
  - Reads return the written values.
- Reset mid-operation: assert `rst` during WAIT of a write of `0xA5A5_A5A5` to 0x8.
  - `ack` never pulses.
  - After reset, a read of 0x8 returns 0.
- Read 0x400 (out of range for `MEM_DEPTH=256`):
  - With `MS_SLAVE_ERR_EN`: `err=1` with `ack`, `rdata=0xDEAD_BEEF`, and a write to 0x400 leaves address 0x0 unchanged.
  - Without it: the access aliases to 0x0.
- Protocol violation: drop `req` during WAIT. `ack` still pulses once at the scheduled cycle, and the write still commits.
